// File: rtl/div_32_seq.sv
// Sequential signed divider producing {remainder, quotient} for the HI/LO pair.
// Restoring division works on operand magnitudes, one quotient bit per clock.
// The signs are applied in a final fix-up cycle. A start/busy/done handshake
// lets the control unit stall while a division is in flight.
module div_32_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic               dbz,
  output logic [2*WIDTH-1:0] P
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state, state_nx;
  logic [WIDTH-1:0]   dvs_mag;   // |divisor|, constant during CALC
  logic [WIDTH-1:0]   rem;       // partial remainder
  logic [WIDTH-1:0]   quo;       // |dividend| shifting out, quotient bits shifting in
  logic [CNT_W-1:0]   cnt;
  logic               sign_q, sign_r;
  logic               div_zero, last_step, accept;
  logic signed [WIDTH:0] shifted, trial;
  logic               qbit;
  logic [WIDTH-1:0]   rem_nx;

  // Unsigned magnitude of a two's-complement value; |MIN| = 2^(W-1) still fits.
  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] x);
    return x[WIDTH-1] ? ('0 - x) : x;
  endfunction

  // Conditional two's-complement negation used to restore result signs.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? ('0 - x) : x;
  endfunction

  assign div_zero  = (divisor == '0);
  assign last_step = (cnt == CNT_W'(WIDTH - 1));
  assign accept    = (state == IDLE) && start && !div_zero;

  // One restoring step: shift in the next dividend bit, try subtracting |divisor|.
  // The trial runs at WIDTH+1 bits so the bit shifted out of rem is not lost.
  always_comb begin
    shifted = $signed({rem, quo[WIDTH-1]});
    trial   = shifted - $signed({1'b0, dvs_mag});
    qbit    = ~trial[WIDTH];
    rem_nx  = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = div_zero ? DONE : CALC;
      CALC:    if (last_step) state_nx = FIX;
      FIX:     state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Registered handshake and result; done is a one-cycle pulse by default-clear.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      dbz  <= 1'b0;
      P    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (div_zero) begin
              done <= 1'b1;
              dbz  <= 1'b1;
              P    <= {dividend, {WIDTH{1'b1}}};
            end else begin
              busy <= 1'b1;
            end
          end
        end
        FIX: begin
          busy <= 1'b0;
          done <= 1'b1;
          dbz  <= 1'b0;
          P    <= {cond_neg(rem, sign_r), cond_neg(quo, sign_q)};
        end
        default: ;
      endcase
    end
  end

  // Datapath: operand capture on accept, then one quotient bit per CALC cycle.
  always_ff @(posedge clock) begin
    if (accept) begin
      dvs_mag <= mag($signed(divisor));
      quo     <= mag($signed(dividend));
      rem     <= '0;
      cnt     <= '0;
      sign_q  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      sign_r  <= dividend[WIDTH-1];
    end else if (state == CALC) begin
      rem <= rem_nx;
      quo <= {quo[WIDTH-2:0], qbit};
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule
